// File: rtl/midi_cc_decoder_pkg.sv
// Shared MIDI/synth definitions: byte-class boundaries, the CC parser state
// encoding and the waveform-select ranges driven by the decoded value.
package midi_cc_decoder_pkg;

  localparam int CC_W = 7;

  // Status byte layout and byte-class lower bounds
  localparam logic [3:0] STATUS_CC  = 4'hB;
  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] SYS_MIN    = 8'hF0;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  // Waveform-select ranges on the oscillator mux input.
  // Codes 32 and 64 fall outside every named range and select rect.
  localparam logic [CC_W-1:0] SINE_MAX = 7'd31;
  localparam logic [CC_W-1:0] TRI_MIN  = 7'd33;
  localparam logic [CC_W-1:0] TRI_MAX  = 7'd63;
  localparam logic [CC_W-1:0] SAW_MIN  = 7'd65;
  localparam logic [CC_W-1:0] SAW_MAX  = 7'd95;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NUM  = 2'd1,
    ST_VAL  = 2'd2,
    ST_SKIP = 2'd3
  } cc_state_e;

  typedef enum logic [1:0] {
    BC_DATA   = 2'd0,
    BC_STATUS = 2'd1,
    BC_SYS    = 2'd2,
    BC_RT     = 2'd3
  } byte_class_e;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_RECT = 2'd3
  } wave_e;

  // Classify a received byte; kept here so the note decoder can share it.
  function automatic byte_class_e midi_byte_class(input logic [7:0] b);
    if (b >= RT_MIN)          return BC_RT;
    else if (b >= SYS_MIN)    return BC_SYS;
    else if (b >= STATUS_MIN) return BC_STATUS;
    else                      return BC_DATA;
  endfunction

  // Map a 7-bit control value onto the oscillator waveform.
  function automatic wave_e wave_select(input logic [CC_W-1:0] v);
    if (v <= SINE_MAX)                     return WAVE_SINE;
    else if (v >= TRI_MIN && v <= TRI_MAX) return WAVE_TRI;
    else if (v >= SAW_MIN && v <= SAW_MAX) return WAVE_SAW;
    else                                   return WAVE_RECT;
  endfunction

endpackage

// File: rtl/midi_cc_decoder_if.sv
// Byte-stream input and decoded control-value outputs of the CC decoder.
// master: byte source / consumer side; slave: the decoder.
interface midi_cc_decoder_if;
  import midi_cc_decoder_pkg::*;

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [CC_W-1:0] cc_value;
  logic            cc_update;
  logic            status_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  cc_value,
    input  cc_update,
    input  status_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output cc_value,
    output cc_update,
    output status_err
  );

endinterface

// File: rtl/midi_cc_decoder.sv
// Extracts one Control Change value (fixed channel + controller number) from
// a deserialised MIDI byte stream and holds it for the waveform-select mux.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no running status; data bytes ignored
//   ST_NUM  | CC for our channel active, next data byte is controller no.
//   ST_VAL  | controller number captured, next data byte is the value
//   ST_SKIP | running status of a message for someone else; data ignored
module midi_cc_decoder
  import midi_cc_decoder_pkg::*;
#(
  parameter int CHANNEL     = 0,
  parameter int CC_NUM      = 70,
  parameter int RESET_VALUE = 0
) (
  input  logic               clk,
  input  logic               rst,
  midi_cc_decoder_if.slave   cc_bus
);

  localparam logic [7:0]      CC_STATUS = {STATUS_CC, 4'(CHANNEL)};
  localparam logic [CC_W-1:0] CC_NUM_L  = CC_W'(CC_NUM);
  localparam logic [CC_W-1:0] RST_VAL_L = CC_W'(RESET_VALUE);

  cc_state_e       state_q, state_d;
  logic [CC_W-1:0] num_q, num_d;
  logic [CC_W-1:0] value_q, value_d;
  logic            update_q, update_d;
  logic            err_q, err_d;
  byte_class_e     byte_class;

  assign byte_class = midi_byte_class(cc_bus.rx_data);

  // State, captured controller number and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      value_q  <= RST_VAL_L;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      value_q  <= value_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  // Next-state decode; only cycles with a valid byte can change anything
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    value_d  = value_q;
    update_d = 1'b0;
    err_d    = err_q;

    if (cc_bus.rx_valid) begin
      unique case (byte_class)
        BC_RT: begin
          // clock/transport bytes may interleave anywhere; transparent
        end
        BC_SYS: begin
          state_d = ST_IDLE;
        end
        BC_STATUS: begin
          if (cc_bus.rx_data == CC_STATUS) begin
            state_d = ST_NUM;
          end else begin
            state_d = ST_SKIP;
          end
          // A value byte was still owed, or a number byte was owed and the
          // new status does not simply restart our own CC message.
          if (state_q == ST_VAL ||
              (state_q == ST_NUM && cc_bus.rx_data != CC_STATUS)) begin
            err_d = 1'b1;
          end
        end
        BC_DATA: begin
          unique case (state_q)
            ST_NUM: begin
              num_d   = cc_bus.rx_data[CC_W-1:0];
              state_d = ST_VAL;
            end
            ST_VAL: begin
              if (num_q == CC_NUM_L) begin
                value_d  = cc_bus.rx_data[CC_W-1:0];
                update_d = 1'b1;
              end
              state_d = ST_NUM;
            end
            default: begin
              // IDLE and SKIP drop stray data bytes
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  assign cc_bus.cc_value   = value_q;
  assign cc_bus.cc_update  = update_q;
  assign cc_bus.status_err = err_q;

endmodule

// File: tb/tb_midi_cc_decoder.sv
// Directed bench for midi_cc_decoder (CHANNEL=0, CC_NUM=70, RESET_VALUE=0).
// Each vector is one clock: inputs applied before the edge, outputs checked
// just after it.
module tb_midi_cc_decoder;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic [6:0] exp_val;
    logic       exp_upd;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  midi_cc_decoder_if cc_bus ();

  midi_cc_decoder #(
    .CHANNEL     (0),
    .CC_NUM      (70),
    .RESET_VALUE (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cc_bus (cc_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic [6:0] ev, input logic eu, input logic ee);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d;
    t.exp_val = ev; t.exp_upd = eu; t.exp_err = ee;
    vecs.push_back(t);
  endfunction

  // valid byte, no reset
  function automatic void b(input logic [7:0] d, input logic [6:0] ev,
                            input logic eu, input logic ee);
    add(1'b0, 1'b1, d, ev, eu, ee);
  endfunction

  task automatic check_outs(input string name, input int idx,
                            input logic [6:0] ev, input logic eu, input logic ee);
    n_tests++;
    if (cc_bus.cc_value !== ev || cc_bus.cc_update !== eu || cc_bus.status_err !== ee) begin
      n_fail++;
      $display("FAIL %s[%0d]: got value=%02h update=%b err=%b, want value=%02h update=%b err=%b",
               name, idx, cc_bus.cc_value, cc_bus.cc_update, cc_bus.status_err, ev, eu, ee);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst             = r;
    cc_bus.rx_valid = v;
    cc_bus.rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // basic CC
    b(8'hB0, 7'h00, 0, 0);
    b(8'h46, 7'h00, 0, 0);
    b(8'h50, 7'h50, 1, 0);
    add(0, 0, 8'h00, 7'h50, 0, 0);
    // running status: two pulses back to back
    b(8'hB0, 7'h50, 0, 0);
    b(8'h46, 7'h50, 0, 0);
    b(8'h10, 7'h10, 1, 0);
    b(8'h46, 7'h10, 0, 0);
    b(8'h60, 7'h60, 1, 0);
    b(8'hF0, 7'h60, 0, 0);
    // filtering: wrong channel, wrong controller, note-on
    b(8'hB1, 7'h60, 0, 0);
    b(8'h46, 7'h60, 0, 0);
    b(8'h7F, 7'h60, 0, 0);
    b(8'hB0, 7'h60, 0, 0);
    b(8'h07, 7'h60, 0, 0);
    b(8'h7F, 7'h60, 0, 0);
    b(8'hF0, 7'h60, 0, 0);
    b(8'h90, 7'h60, 0, 0);
    b(8'h46, 7'h60, 0, 0);
    b(8'h7F, 7'h60, 0, 0);
    // real-time byte between number and value
    b(8'hB0, 7'h60, 0, 0);
    b(8'h46, 7'h60, 0, 0);
    b(8'hF8, 7'h60, 0, 0);
    b(8'h20, 7'h20, 1, 0);
    // system byte kills running status; later data ignored
    b(8'hB0, 7'h20, 0, 0);
    b(8'h46, 7'h20, 0, 0);
    b(8'hF0, 7'h20, 0, 0);
    b(8'h30, 7'h20, 0, 0);
    b(8'h46, 7'h20, 0, 0);
    b(8'h31, 7'h20, 0, 0);
    // identical value re-sent still pulses
    b(8'hB0, 7'h20, 0, 0);
    b(8'h46, 7'h20, 0, 0);
    b(8'h20, 7'h20, 1, 0);
    // rx_valid low ignores bus contents
    b(8'h46, 7'h20, 0, 0);
    add(0, 0, 8'h55, 7'h20, 0, 0);
    b(8'h55, 7'h55, 1, 0);
    // real-time bytes inside running status, extremes of value range
    b(8'hF8, 7'h55, 0, 0);
    b(8'h46, 7'h55, 0, 0);
    b(8'hFF, 7'h55, 0, 0);
    b(8'h7F, 7'h7F, 1, 0);
    b(8'h46, 7'h7F, 0, 0);
    b(8'h00, 7'h00, 1, 0);
    // interrupted value byte: sticky error
    b(8'hB0, 7'h00, 0, 0);
    b(8'h46, 7'h00, 0, 0);
    b(8'h90, 7'h00, 0, 1);
    b(8'hF0, 7'h00, 0, 1);
    b(8'hB0, 7'h00, 0, 1);
    b(8'h46, 7'h00, 0, 1);
    b(8'h11, 7'h11, 1, 1);
    // reset between number and value, reset wins over rx_valid
    b(8'hB0, 7'h11, 0, 1);
    b(8'h46, 7'h11, 0, 1);
    add(1, 1, 8'h22, 7'h00, 0, 0);
    b(8'h22, 7'h00, 0, 0);
    add(0, 0, 8'h00, 7'h00, 0, 0);
    // interrupted number byte by a foreign status
    b(8'hB0, 7'h00, 0, 0);
    b(8'hB3, 7'h00, 0, 1);
    add(1, 0, 8'h00, 7'h00, 0, 0);

    cc_bus.rx_valid = 1'b0;
    cc_bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check_outs("idle", i, 7'h00, 1'b0, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].data);
      check_outs("vec", i, vecs[i].exp_val, vecs[i].exp_upd, vecs[i].exp_err);
    end

    // error flag holds across quiet cycles until reset
    cycle(1'b0, 1'b1, 8'hB0);
    cycle(1'b0, 1'b1, 8'h46);
    cycle(1'b0, 1'b1, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check_outs("err_hold", i, 7'h00, 1'b0, 1'b1);
    end
    cycle(1'b1, 1'b0, 8'h00);
    check_outs("err_clear", 0, 7'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
